// File: rtl/uart_core.sv
// -----------------------------------------------------------------------------
// uart_core -- parametrised full-duplex UART with valid/ready byte interfaces.
//
// TX half : latches a byte on tx_valid & tx_ready and shifts out
//           start / DATA_BITS data (LSB first) / [parity] / STOP_BITS stop.
// RX half : 2-flop synchroniser, half-bit start qualification (glitch filter),
//           centre sampling, framing / parity error flags, overrun pulse.
//
// Optional feature macro: UART_PARITY_EN (adds a parity bit to both halves;
// PARITY_ODD selects odd parity). Ports are identical in both builds.
//
// Ports:
//   clock          system clock, posedge
//   reset          synchronous, active-high
//   tx_data[7:0]   byte to send (bits above DATA_BITS ignored)
//   tx_valid       tx_data valid
//   tx_ready       TX idle, can accept a byte
//   serial_tx      registered serial output, idles high
//   serial_rx      asynchronous serial input
//   rx_data[7:0]   last received byte, zero-extended
//   rx_valid       rx_data holds an unread byte
//   rx_ready       consumer accepts rx_data
//   rx_frame_err   first stop bit sampled low (qualified by rx_valid)
//   rx_parity_err  parity mismatch (qualified by rx_valid)
//   rx_overrun     one-cycle pulse when an unread byte is overwritten
// -----------------------------------------------------------------------------
module uart_core #(
   parameter int CLOCK_HZ   = 12_000_000,
   parameter int BAUD_HZ    = 9_600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       serial_tx,
   input  logic       serial_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_frame_err,
   output logic       rx_parity_err,
   output logic       rx_overrun
);

   localparam int DIV = CLOCK_HZ / BAUD_HZ;
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
   localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);
   localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);
   localparam logic [7:0]    D_MASK = 8'((1 << DATA_BITS) - 1);
   localparam logic          P_ODD  = 1'(PARITY_ODD);

`ifdef UART_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   generate
      if (DIV < 4) begin : g_bad_div
         $error("uart_core: CLOCK_HZ/BAUD_HZ must be >= 4");
      end
      if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
         $error("uart_core: DATA_BITS must be 5..8");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
         $error("uart_core: STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ---------------------------------------------------------------- TX ----
   state_t          tx_state_q, tx_state_d;
   logic [TW-1:0]   tx_timer_q, tx_timer_d;
   logic [2:0]      tx_bit_q,   tx_bit_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            tx_par_q,   tx_par_d;
   logic            tx_stop_q,  tx_stop_d;   // second stop period still owed
   logic            tx_line_q,  tx_line_d;
   logic            tx_rdy_q,   tx_rdy_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_timer_d = tx_timer_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_stop_d  = tx_stop_q;

      case (tx_state_q)
         S_IDLE: begin
            if (tx_valid && tx_rdy_q) begin
               tx_shift_d = tx_data & D_MASK;
               tx_par_d   = (^(tx_data & D_MASK)) ^ P_ODD;
               tx_timer_d = T_FULL;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_timer_q == '0) begin
               tx_timer_d = T_FULL;
               tx_bit_d   = B_LAST;
               tx_state_d = S_DATA;
            end else begin
               tx_timer_d = tx_timer_q - 1'b1;
            end
         end
         S_DATA: begin
            if (tx_timer_q == '0) begin
               tx_timer_d = T_FULL;
               if (tx_bit_q == '0) begin
                  tx_stop_d  = (STOP_BITS == 2);
                  tx_state_d = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q - 1'b1;
                  tx_shift_d = tx_shift_q >> 1;
               end
            end else begin
               tx_timer_d = tx_timer_q - 1'b1;
            end
         end
         S_PARITY: begin
            if (tx_timer_q == '0) begin
               tx_timer_d = T_FULL;
               tx_state_d = S_STOP;
            end else begin
               tx_timer_d = tx_timer_q - 1'b1;
            end
         end
         S_STOP: begin
            if (tx_timer_q == '0) begin
               if (tx_stop_q) begin
                  tx_stop_d  = 1'b0;
                  tx_timer_d = T_FULL;
               end else begin
                  tx_state_d = S_IDLE;
               end
            end else begin
               tx_timer_d = tx_timer_q - 1'b1;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase

      // Line level and ready are registered from the next state so that
      // serial_tx drops on the cycle right after the handshake edge.
      case (tx_state_d)
         S_START:  tx_line_d = 1'b0;
         S_DATA:   tx_line_d = tx_shift_d[0];
         S_PARITY: tx_line_d = tx_par_d;
         default:  tx_line_d = 1'b1;
      endcase
      tx_rdy_d = (tx_state_d == S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state_q <= S_IDLE;
         tx_timer_q <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_stop_q  <= 1'b0;
         tx_line_q  <= 1'b1;
         tx_rdy_q   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_timer_q <= tx_timer_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_stop_q  <= tx_stop_d;
         tx_line_q  <= tx_line_d;
         tx_rdy_q   <= tx_rdy_d;
      end
   end

   assign serial_tx = tx_line_q;
   assign tx_ready  = tx_rdy_q;

   // ---------------------------------------------------------------- RX ----
   logic rx_meta_q, rx_sync_q;
   logic rx_s;

   state_t                 rx_state_q, rx_state_d;
   logic [TW-1:0]          rx_timer_q, rx_timer_d;
   logic [2:0]             rx_bit_q,   rx_bit_d;
   logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
   logic                   rx_par_q,   rx_par_d;

   logic [7:0] rx_data_q,  rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rx_fe_q,    rx_fe_d;
   logic       rx_pe_q,    rx_pe_d;
   logic       rx_ovr_q,   rx_ovr_d;
   logic       rx_done;

   assign rx_s = rx_sync_q;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_timer_d = rx_timer_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      rx_done    = 1'b0;

      case (rx_state_q)
         S_IDLE: begin
            if (!rx_s) begin
               rx_timer_d = T_HALF;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            // Re-check at mid start bit; a high line means a glitch.
            if (rx_timer_q == '0) begin
               if (rx_s) begin
                  rx_state_d = S_IDLE;
               end else begin
                  rx_timer_d = T_FULL;
                  rx_bit_d   = B_LAST;
                  rx_state_d = S_DATA;
               end
            end else begin
               rx_timer_d = rx_timer_q - 1'b1;
            end
         end
         S_DATA: begin
            if (rx_timer_q == '0) begin
               rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
               rx_timer_d = T_FULL;
               if (rx_bit_q == '0) begin
                  rx_state_d = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  rx_bit_d = rx_bit_q - 1'b1;
               end
            end else begin
               rx_timer_d = rx_timer_q - 1'b1;
            end
         end
         S_PARITY: begin
            if (rx_timer_q == '0) begin
               rx_par_d   = rx_s;
               rx_timer_d = T_FULL;
               rx_state_d = S_STOP;
            end else begin
               rx_timer_d = rx_timer_q - 1'b1;
            end
         end
         S_STOP: begin
            // Only the first stop bit centre is looked at; returning to IDLE
            // right away lets a second stop bit or a back-to-back start pass.
            if (rx_timer_q == '0) begin
               rx_done    = 1'b1;
               rx_state_d = S_IDLE;
            end else begin
               rx_timer_d = rx_timer_q - 1'b1;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      rx_fe_d    = rx_fe_q;
      rx_pe_d    = rx_pe_q;
      rx_ovr_d   = 1'b0;
      if (rx_done) begin
         // A waiting unread byte is overwritten unless it is taken this cycle.
         rx_data_d  = 8'(rx_shift_q);
         rx_valid_d = 1'b1;
         rx_fe_d    = ~rx_s;
         rx_pe_d    = PAR_EN & ((^rx_shift_q) ^ rx_par_q ^ P_ODD);
         rx_ovr_d   = rx_valid_q & ~rx_ready;
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_timer_q <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_fe_q    <= 1'b0;
         rx_pe_q    <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         rx_meta_q  <= serial_rx;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_timer_q <= rx_timer_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_fe_q    <= rx_fe_d;
         rx_pe_q    <= rx_pe_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_frame_err  = rx_fe_q;
   assign rx_parity_err = rx_pe_q;
   assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core, DIV = 16/2 = 8.
//   u0: DATA_BITS=8, STOP_BITS=1; serial_rx muxed between loopback and a
//       bench-driven line.
//   u1: DATA_BITS=5, STOP_BITS=2; always looped back.
module tb_uart_core;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic [7:0] tx_data0 = '0, tx_data1 = '0;
   logic       tx_valid0 = 1'b0, tx_valid1 = 1'b0;
   logic       tx_ready0, tx_ready1;
   logic       serial_tx0, serial_tx1;
   logic       rx_line0;
   logic [7:0] rx_data0, rx_data1;
   logic       rx_valid0, rx_valid1;
   logic       rx_ready0 = 1'b1;
   logic       rx_fe0, rx_fe1, rx_pe0, rx_pe1, rx_ovr0, rx_ovr1;

   logic       lb_sel = 1'b1;
   logic       drv0   = 1'b1;

   int n_chk  = 0;
   int n_fail = 0;

   // Scoreboard side: every consumed byte and every overrun pulse.
   int         rx_cnt0 = 0, rx_cnt1 = 0, ovr_cnt0 = 0;
   logic [7:0] cap_d0 = '0, cap_d1 = '0;
   logic       cap_fe0 = 1'b0, cap_pe0 = 1'b0, cap_fe1 = 1'b0;

   assign rx_line0 = lb_sel ? serial_tx0 : drv0;

   always #5 clk = ~clk;

   uart_core #(.CLOCK_HZ(16), .BAUD_HZ(2), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
      .clock(clk), .reset(reset),
      .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
      .serial_tx(serial_tx0), .serial_rx(rx_line0),
      .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
      .rx_frame_err(rx_fe0), .rx_parity_err(rx_pe0), .rx_overrun(rx_ovr0)
   );

   uart_core #(.CLOCK_HZ(16), .BAUD_HZ(2), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
      .clock(clk), .reset(reset),
      .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
      .serial_tx(serial_tx1), .serial_rx(serial_tx1),
      .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(1'b1),
      .rx_frame_err(rx_fe1), .rx_parity_err(rx_pe1), .rx_overrun(rx_ovr1)
   );

   always @(posedge clk) begin
      if (rx_valid0 && rx_ready0) begin
         rx_cnt0 <= rx_cnt0 + 1;
         cap_d0  <= rx_data0;
         cap_fe0 <= rx_fe0;
         cap_pe0 <= rx_pe0;
      end
      if (rx_ovr0) ovr_cnt0 <= ovr_cnt0 + 1;
      if (rx_valid1) begin
         rx_cnt1 <= rx_cnt1 + 1;
         cap_d1  <= rx_data1;
         cap_fe1 <= rx_fe1 | rx_pe1 | rx_ovr1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Handshake one byte on u0; the wait for tx_ready is bounded.
   task automatic send0(input logic [7:0] b);
      int t = 0;
      while (!tx_ready0 && t < 200) begin tick(); t++; end
      chk("send0_ready", {31'd0, tx_ready0}, 32'd1);
      tx_data0  = b;
      tx_valid0 = 1'b1;
      tick();
      tx_valid0 = 1'b0;
   endtask

   // Bench-driven frame on u0's serial_rx, 8 cycles per bit.
   task automatic drive_frame(input logic [7:0] b, input logic par_en,
                              input logic par, input logic stop);
      drv0 = 1'b0; repeat (8) tick();
      for (int i = 0; i < 8; i++) begin drv0 = b[i]; repeat (8) tick(); end
      if (par_en) begin drv0 = par; repeat (8) tick(); end
      drv0 = stop; repeat (8) tick();
      drv0 = 1'b1; repeat (24) tick();
   endtask

   initial begin
      logic [9:0] frame;
      int base;

      // ---- reset values
      repeat (3) tick();
      chk("rst_serial_tx", {31'd0, serial_tx0}, 32'd1);
      chk("rst_tx_ready",  {31'd0, tx_ready0},  32'd0);
      chk("rst_rx_valid",  {31'd0, rx_valid0},  32'd0);
      chk("rst_rx_data",   {24'd0, rx_data0},   32'd0);
      chk("rst_flags",     {29'd0, rx_fe0, rx_pe0, rx_ovr0}, 32'd0);
      reset = 1'b0;
      tick();
      chk("tx_ready_after_rst", {31'd0, tx_ready0}, 32'd1);

      // ---- 1: TX 0x41 bit-by-bit, tx_ready back after exactly 80 cycles
      frame = {1'b1, 8'h41, 1'b0};
      base  = rx_cnt0;
      tx_data0  = 8'h41;
      tx_valid0 = 1'b1;
      tick();
      tx_valid0 = 1'b0;
`ifndef UART_PARITY_EN
      for (int k = 0; k < 80; k++) begin
         if (k % 4 == 0 || k % 8 == 7)
            chk($sformatf("tx41_bit_k%0d", k), {31'd0, serial_tx0}, {31'd0, frame[k/8]});
         if (k % 8 == 7)
            chk($sformatf("tx41_busy_k%0d", k), {31'd0, tx_ready0}, 32'd0);
         tick();
      end
      chk("tx41_ready_at_80", {31'd0, tx_ready0}, 32'd1);
`endif
      repeat (20) tick();
      chk("tx41_loop_cnt",  rx_cnt0, base + 1);
      chk("tx41_loop_data", {24'd0, cap_d0}, 32'h41);

      // ---- 2: loopback 0xA5 (u0) and 0x1F, then 0xE3 masked to 0x03 (u1)
      base = rx_cnt0;
      tx_data1  = 8'h1F;
      tx_valid1 = 1'b1;
      send0(8'hA5);
      tx_valid1 = 1'b0;
      repeat (110) tick();
      chk("lb_a5_count", rx_cnt0, base + 1);
      chk("lb_a5_data",  {24'd0, cap_d0}, 32'hA5);
      chk("lb_a5_flags", {30'd0, cap_fe0, cap_pe0}, 32'd0);
      chk("lb_1f_count", rx_cnt1, 1);
      chk("lb_1f_data",  {24'd0, cap_d1}, 32'h1F);
      chk("lb_1f_flags", {31'd0, cap_fe1}, 32'd0);
      tx_data1  = 8'hE3;
      tx_valid1 = 1'b1;
      tick();
      tx_valid1 = 1'b0;
      repeat (100) tick();
      chk("lb_e3_count", rx_cnt1, 2);
      chk("lb_e3_zext",  {24'd0, cap_d1}, 32'h03);

      // ---- 3: 2-cycle glitch rejected, then a real 0x3C frame
      lb_sel = 1'b0;
      base   = rx_cnt0;
      drv0 = 1'b0; repeat (2) tick();
      drv0 = 1'b1; repeat (30) tick();
      chk("glitch_no_valid", {31'd0, rx_valid0}, 32'd0);
      chk("glitch_no_byte",  rx_cnt0, base);
      drive_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      chk("after_glitch_cnt",  rx_cnt0, base + 1);
      chk("after_glitch_data", {24'd0, cap_d0}, 32'h3C);
      chk("after_glitch_fe",   {31'd0, cap_fe0}, 32'd0);

      // ---- 4: framing error, 0x55 with stop bit held low
`ifndef UART_PARITY_EN
      base = rx_cnt0;
      drive_frame(8'h55, 1'b0, 1'b0, 1'b0);
      chk("ferr_cnt",  rx_cnt0, base + 1);
      chk("ferr_data", {24'd0, cap_d0}, 32'h55);
      chk("ferr_flag", {31'd0, cap_fe0}, 32'd1);
      repeat (20) tick();
      chk("ferr_no_extra", rx_cnt0, base + 1);
`endif

      // ---- 6: parity build only
`ifdef UART_PARITY_EN
      lb_sel = 1'b1;
      send0(8'h03);
      repeat (75) tick();                 // now mid parity slot (cycles 72..79)
      chk("par_tx_bit", {31'd0, serial_tx0}, 32'd0);
      repeat (40) tick();
      lb_sel = 1'b0;
      base = rx_cnt0;
      drive_frame(8'h03, 1'b1, 1'b1, 1'b1);
      chk("par_cnt",  rx_cnt0, base + 1);
      chk("par_data", {24'd0, cap_d0}, 32'h03);
      chk("par_err",  {31'd0, cap_pe0}, 32'd1);
`endif

      // ---- 5: overrun with rx_ready low, two back-to-back frames
      lb_sel    = 1'b1;
      rx_ready0 = 1'b0;
      base      = ovr_cnt0;
      send0(8'h11);
      send0(8'h22);
      repeat (120) tick();
      chk("ovr_pulses",  ovr_cnt0, base + 1);
      chk("ovr_valid",   {31'd0, rx_valid0}, 32'd1);
      chk("ovr_data",    {24'd0, rx_data0}, 32'h22);
      chk("ovr_low_now", {31'd0, rx_ovr0}, 32'd0);
      rx_ready0 = 1'b1;
      tick();
      chk("ovr_consumed", {31'd0, rx_valid0}, 32'd0);
      chk("ovr_cap_data", {24'd0, cap_d0}, 32'h22);

      // ---- reset mid TX frame
      base = rx_cnt0;
      send0(8'h00);
      repeat (20) tick();
      chk("mid_frame_low", {31'd0, serial_tx0}, 32'd0);
      reset = 1'b1;
      tick();
      chk("rst_mid_serial_tx", {31'd0, serial_tx0}, 32'd1);
      chk("rst_mid_tx_ready",  {31'd0, tx_ready0},  32'd0);
      reset = 1'b0;
      tick();
      chk("rst_mid_ready_back", {31'd0, tx_ready0}, 32'd1);
      repeat (100) tick();
      chk("rst_mid_no_rx", rx_cnt0, base);
      chk("rst_mid_idle_line", {31'd0, serial_tx0}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART with valid/ready byte interfaces, configurable data and stop bits, a synchronised and glitch-filtered receiver, and framing/overrun/parity error reporting. It sits between the board serial pins and on-chip byte producers and consumers, and it replaces the fixed 8N1 echo UART. Its TX and RX halves are independent and run from one clock.

## Interface
Parameters:
- CLOCK_HZ, 12_000_000, system clock frequency.
- BAUD_HZ, 9_600, line rate. DIV = CLOCK_HZ / BAUD_HZ (integer division) is the bit period in cycles. DIV >= 4 is required; elaboration fails otherwise.
- DATA_BITS, 8, data bits per frame, 5..8. Transmitted and received LSB first.
- STOP_BITS, 1, stop bits transmitted, 1 or 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send; bits above DATA_BITS are ignored.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  high only while the TX FSM is IDLE.
- serial_tx  out  1  registered serial output; idles high.
- serial_rx  in  1  asynchronous serial input.
- rx_data  out  8  last received byte, zero-extended above DATA_BITS.
- rx_valid  out  1  rx_data holds an unread byte.
- rx_ready  in  1  consumer accepts rx_data.
- rx_frame_err  out  1  qualified by rx_valid: the first stop bit was sampled as 0.
- rx_parity_err  out  1  qualified by rx_valid: the parity check failed.
- rx_overrun  out  1  one-cycle pulse when a byte is lost.

## Operation
- TX FSM states: IDLE -> START -> DATA -> PARITY (compiled in only) -> STOP -> IDLE.
  - A handshake is tx_valid & tx_ready at a posedge. The byte is latched at that edge and the FSM leaves IDLE.
  - Each state holds its line level for exactly DIV cycles: START = 0; DATA = shift[0]; PARITY = parity bit; STOP = 1 for STOP_BITS*DIV cycles.
  - The DATA state uses a down-counter from DATA_BITS-1 to 0.
- RX path: serial_rx passes through a 2-flop synchroniser. All RX decisions use the synchronised signal.
- RX FSM states: IDLE -> START -> DATA -> PARITY (compiled in only) -> STOP -> IDLE.
  - IDLE: on a synchronised 0, go to START and load the timer with DIV/2-1.
  - START: at timer 0, re-sample. If the line is 1, this is a false start; return to IDLE with no output. Otherwise go to DATA with the timer at DIV-1.
  - DATA/PARITY: sample once per DIV cycles at bit centre and shift right into the MSB of a DATA_BITS-wide register.
  - STOP: sample the centre of the first stop bit only, then return to IDLE on the next cycle, so back-to-back frames and a second stop bit are tolerated.
- RX output register: completion loads rx_data, rx_frame_err and rx_parity_err and sets rx_valid.
  - rx_valid clears on rx_valid & rx_ready.
  - If a frame completes while rx_valid=1 and rx_ready=0, the new byte overwrites the register, rx_valid stays 1, and rx_overrun pulses for 1 cycle.
  - If rx_ready is high in the same cycle a frame completes, the old byte is consumed and the new byte is loaded. No overrun.
- Timer width is $clog2(DIV). Counters never wrap outside their reload points.

## Timing
- Reset values: serial_tx=1, tx_ready=0, rx_valid=0, rx_data=0, rx_frame_err=0, rx_parity_err=0, rx_overrun=0. Both FSMs go to IDLE, and the synchroniser flops are set to 1.
- tx_ready rises on the first cycle after reset deasserts.
- Reset asserted mid-frame: serial_tx=1 on the following cycle, and any partial RX frame is discarded.
- TX: handshake at edge N gives serial_tx=0 from cycle N+1. The frame lasts (1+DATA_BITS+P+STOP_BITS)*DIV cycles, where P = 1 if parity is compiled in, else 0. tx_ready is high on the first cycle after the last stop period.
- RX: rx_valid rises 1 cycle after the mid-stop sample. That is about 2 + DIV/2 cycles, plus synchroniser delay, after the stop bit's leading edge.
- rx_overrun and rx_valid set are simultaneous on an overrun load.

## Configuration
- UART_PARITY_EN defined: a PARITY state is added to both FSMs. The parity bit is sent after the data bits: the XOR of the data bits, XOR PARITY_ODD. RX checks it and reports rx_parity_err.
- UART_PARITY_EN undefined: no parity bit is sent or expected, P = 0, and rx_parity_err is tied to 0.
- Ports are identical in both builds.

## Test plan
Common setup: CLOCK_HZ=16, BAUD_HZ=2, so DIV=8. Default build is DATA_BITS=8, STOP_BITS=1, no parity, with serial_tx looped to serial_rx unless stated.

1. TX 0x41: serial_tx = 0 for 8 cycles, then 1,0,0,0,0,0,1,0 at 8 cycles each, then 1 for 8 cycles. tx_ready returns exactly 80 cycles after the handshake.
2. Loopback 0xA5 with rx_ready=1: one rx_valid pulse, rx_data=0xA5, both error flags 0. Repeat with DATA_BITS=5 and STOP_BITS=2, sending 0x1F: rx_data=0x1F.
3. A 2-cycle low glitch on serial_rx gives no rx_valid, and the RX FSM returns to IDLE. A following real frame carrying 0x3C is received correctly.
4. Drive a frame of 0x55 with the stop bit held 0: rx_valid=1, rx_data=0x55, rx_frame_err=1.
5. Send two frames, 0x11 then 0x22, back-to-back with rx_ready=0: one rx_overrun pulse and rx_data=0x22. Then assert reset mid-TX-frame: serial_tx=1 on the next cycle.
6. With UART_PARITY_EN and PARITY_ODD=0: sending 0x03 puts parity bit 0 on the line. Receiving 0x03 with parity bit 1 gives rx_parity_err=1 and rx_data=0x03.
